// File: rtl/rom_fetch_seq.sv
// rom_fetch_seq: read sequencer for the dense-layer weight ROM.
// Walks NUM_ROWS*ROW_LEN addresses from BASE_ADDR, absorbs the ROM's 1-cycle read latency in a
// 2-entry first-word-fall-through buffer and presents words on a valid/ready stream tagged with
// end-of-row (w_last) and end-of-pass (w_end).
// Optional feature: define ROM_FETCH_ABORT_EN to add the abort port (cancel a pass, no done).
module rom_fetch_seq #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned NUM_ROWS   = 4,
  parameter int unsigned ROW_LEN    = 16,
  parameter int unsigned BASE_ADDR  = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
`ifdef ROM_FETCH_ABORT_EN
  input  logic                  abort,
`endif
  output logic                  busy,
  output logic                  done,
  output logic                  rom_ena,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_q,
  output logic [DATA_WIDTH-1:0] w_data,
  output logic                  w_valid,
  input  logic                  w_ready,
  output logic                  w_last,
  output logic                  w_end
);

  localparam int unsigned Total = NUM_ROWS * ROW_LEN;
  localparam int unsigned IdxW  = $clog2(Total) + 1;
  localparam int unsigned ColW  = $clog2(ROW_LEN) + 1;
  localparam logic [IdxW-1:0] TotalIdx = IdxW'(Total);
  localparam logic [IdxW-1:0] LastIdx  = IdxW'(Total - 1);
  localparam logic [ColW-1:0] LastCol  = ColW'(ROW_LEN - 1);
  localparam logic [ADDR_WIDTH-1:0] BaseAddr = ADDR_WIDTH'(BASE_ADDR);

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

  state_e                state_q;
  logic                  done_q;
  logic [IdxW-1:0]       idx_q;
  logic [ColW-1:0]       col_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  // Read issued last cycle, with the tags computed when it was issued
  logic                  infl_q;
  logic                  infl_last_q;
  logic                  infl_end_q;
  // 2-entry buffer
  logic [DATA_WIDTH-1:0] mem_data_q [2];
  logic                  mem_last_q [2];
  logic                  mem_end_q  [2];
  logic                  rd_ptr_q;
  logic                  wr_ptr_q;
  logic [1:0]            count_q;

  logic                  abort_req;
  logic                  fifo_valid;
  logic                  pop;
  logic [2:0]            occ;
  logic                  issue;
  logic [1:0]            count_nxt;
  logic [ADDR_WIDTH-1:0] addr_issue;

`ifdef ROM_FETCH_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  // Issue decision, buffer bookkeeping and stream/ROM outputs
  always_comb begin
    fifo_valid = (count_q != 2'd0);
    pop        = fifo_valid & w_ready;
    // Occupancy counts the word already in flight; a pop this cycle frees a slot
    occ        = {1'b0, count_q} + {2'b00, infl_q};
    issue      = (state_q == StRun) && (idx_q < TotalIdx) && !abort_req &&
                 (occ < (3'd2 + {2'b00, pop}));
    count_nxt  = count_q + {1'b0, infl_q} - {1'b0, pop};
    addr_issue = BaseAddr + ADDR_WIDTH'(idx_q);

    rom_ena  = issue;
    rom_addr = issue ? addr_issue : addr_q;
    w_valid  = fifo_valid;
    w_data   = fifo_valid ? mem_data_q[rd_ptr_q] : '0;
    w_last   = fifo_valid ? mem_last_q[rd_ptr_q] : 1'b0;
    w_end    = fifo_valid ? mem_end_q[rd_ptr_q]  : 1'b0;
    busy     = (state_q != StIdle);
    done     = done_q;
  end

  // Sequencer FSM, read counters, in-flight capture and buffer storage
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      done_q      <= 1'b0;
      idx_q       <= '0;
      col_q       <= '0;
      addr_q      <= BaseAddr;
      infl_q      <= 1'b0;
      infl_last_q <= 1'b0;
      infl_end_q  <= 1'b0;
      rd_ptr_q    <= 1'b0;
      wr_ptr_q    <= 1'b0;
      count_q     <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        mem_data_q[i] <= '0;
        mem_last_q[i] <= 1'b0;
        mem_end_q[i]  <= 1'b0;
      end
    end else if (abort_req) begin
      // Cancel: drop buffered and in-flight words, no done pulse
      state_q  <= StIdle;
      done_q   <= 1'b0;
      idx_q    <= '0;
      col_q    <= '0;
      infl_q   <= 1'b0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      done_q <= 1'b0;
      infl_q <= issue;
      if (issue) begin
        addr_q      <= addr_issue;
        idx_q       <= idx_q + IdxW'(1);
        col_q       <= (col_q == LastCol) ? '0 : col_q + ColW'(1);
        infl_last_q <= (col_q == LastCol);
        infl_end_q  <= (idx_q == LastIdx);
      end
      if (infl_q) begin
        mem_data_q[wr_ptr_q] <= rom_q;
        mem_last_q[wr_ptr_q] <= infl_last_q;
        mem_end_q[wr_ptr_q]  <= infl_end_q;
        wr_ptr_q             <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_nxt;

      unique case (state_q)
        StIdle: begin
          // A start coinciding with the done pulse belongs to the finishing pass: ignore it
          if (start && !done_q) begin
            state_q <= StRun;
            idx_q   <= '0;
            col_q   <= '0;
          end
        end
        StRun: begin
          if (issue && (idx_q == LastIdx)) begin
            state_q <= StDrain;
          end
        end
        StDrain: begin
          // Leave as the last word is handed off so done lands the cycle after it
          if (count_nxt == 2'd0) begin
            state_q <= StIdle;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
